// File: rtl/cache_pkg.sv
// Shared definitions for the data cache controller and the cache array it drives.
package cache_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_SET_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        REFILL,
        WR_THRU
    } cache_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer for a direct-mapped, one-word-per-line, write-through/write-allocate
// data cache: serves hits at zero stall, refills on read miss, forwards stores to memory.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SET_WIDTH  = DEFAULT_SET_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_din,
    output logic                  cache_wen,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_dout,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int TAG_LSB = SET_WIDTH + 2;

    cache_state_t          state_q;
    cache_state_t          state_d;
    logic [DATA_WIDTH-1:2] addr_q;
    logic [DATA_WIDTH-1:2] addr_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] line_addr;
    logic                  hit_inc;
    logic                  miss_inc;

    // Only the word address is kept; rebuilt as tag | set | zero byte offset.
    assign line_addr = {addr_q[DATA_WIDTH-1:TAG_LSB], addr_q[TAG_LSB-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_wen) begin
                    addr_d  = cpu_addr[DATA_WIDTH-1:2];
                    data_d  = cpu_wdata;
                    state_d = WR_THRU;
                end else if (cpu_ren) begin
                    if (cache_hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        addr_d   = cpu_addr[DATA_WIDTH-1:2];
                        miss_inc = 1'b1;
                        state_d  = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                // Read data goes through data_q so no output depends on mem_rdata.
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            WR_THRU: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_rdata  = cache_dout;
        cache_addr = (state_q == IDLE) ? cpu_addr : line_addr;
        cache_din  = data_q;
        cache_wen  = (state_q == REFILL) || ((state_q == WR_THRU) && mem_ack);
        mem_addr   = line_addr;
        mem_wdata  = data_q;
        mem_req    = (state_q == RD_MISS) || (state_q == WR_THRU);
        mem_we     = (state_q == WR_THRU);
        stall      = (state_q != IDLE) || cpu_wen || (cpu_ren && !cache_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized transactions
// scored against a transaction-level model of cache, memory and counters.
module tb_cache_ctrl;

    localparam int DW      = 32;
    localparam int SW      = 6;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ren = 1'b0;
    logic          cpu_wen = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic [DW-1:0] cache_addr;
    logic [DW-1:0] cache_din;
    logic          cache_wen;
    logic          cache_hit;
    logic [DW-1:0] cache_dout;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    cache_ctrl #(.DATA_WIDTH(DW), .SET_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ren    (cpu_ren),
        .cpu_wen    (cpu_wen),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .cache_addr (cache_addr),
        .cache_din  (cache_din),
        .cache_wen  (cache_wen),
        .cache_hit  (cache_hit),
        .cache_dout (cache_dout),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Sibling cache array, written only by the controller's cache port.
    logic          env_valid [64] = '{default: 1'b0};
    logic [23:0]   env_tag   [64] = '{default: 24'h0};
    logic [DW-1:0] env_data  [64] = '{default: 32'h0};

    always_comb begin
        cache_hit  = env_valid[cache_addr[7:2]] && (env_tag[cache_addr[7:2]] == cache_addr[31:8]);
        cache_dout = env_data[cache_addr[7:2]];
    end

    always @(posedge clk) begin
        if (cache_wen) begin
            env_valid[cache_addr[7:2]] <= 1'b1;
            env_tag[cache_addr[7:2]]   <= cache_addr[31:8];
            env_data[cache_addr[7:2]]  <= cache_din;
        end
    end

    // Reference model: expected cache lines, memory image, counter values.
    logic          ref_valid [64] = '{default: 1'b0};
    logic [23:0]   ref_tag   [64] = '{default: 24'h0};
    logic [DW-1:0] ref_data  [64] = '{default: 32'h0};
    logic [DW-1:0] ref_mem [logic [DW-1:0]];
    int            exp_hits   = 0;
    int            exp_misses = 0;
    int            n_vec      = 0;
    int            n_err      = 0;
    int            n_txn      = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        check("rst_hit_count", DW'(hit_count), 0);
        check("rst_miss_count", DW'(miss_count), 0);
        check("rst_mem_req", DW'(mem_req), 0);
        check("rst_stall", DW'(stall), 0);
    endtask

    // One CPU transaction; called #1 after a rising edge, returns #1 after a rising edge.
    task automatic run_txn(input bit do_wr, input bit do_rd, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input int k, input bit scramble,
                           input logic [DW-1:0] alt_addr);
        int            idx;
        logic [23:0]   tag;
        bit            exp_hit;
        logic [DW-1:0] rd_val;
        logic [DW-1:0] exp_rdata;
        int            exp_stall;
        int            stalls;
        int            req_cycles;
        bit            acked;
        bit            done;
        bit            idle_op;

        idx       = int'(addr[7:2]);
        tag       = addr[31:8];
        idle_op   = !do_wr && !do_rd;
        exp_hit   = ref_valid[idx] && (ref_tag[idx] == tag);
        rd_val    = '0;
        exp_rdata = '0;
        if (do_wr) begin
            exp_stall = 1 + k;
        end else if (do_rd && exp_hit) begin
            exp_stall = 0;
            exp_rdata = ref_data[idx];
        end else if (do_rd) begin
            if (!ref_mem.exists(addr)) ref_mem[addr] = $urandom;
            rd_val    = ref_mem[addr];
            exp_rdata = rd_val;
            exp_stall = k + 2;
        end else begin
            exp_stall = 0;
        end

        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wen   = do_wr;
        cpu_ren   = do_rd;
        mem_ack   = idle_op;
        mem_rdata = $urandom;
        stalls = 0; req_cycles = 0; acked = 1'b0; done = 1'b0;

        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req && !acked) begin
                    req_cycles++;
                    if (req_cycles == 1) begin
                        check("mem_addr", mem_addr, addr);
                        check("mem_we", DW'(mem_we), DW'(do_wr));
                        if (do_wr) check("mem_wdata", mem_wdata, wdata);
                    end
                    if (req_cycles == k) begin
                        mem_ack = 1'b1;
                        if (!do_wr) mem_rdata = rd_val;
                        #1;
                        if (do_wr) begin
                            check("wr_cache_wen", DW'(cache_wen), 1);
                            check("wr_cache_addr", cache_addr, addr);
                            check("wr_cache_din", cache_din, wdata);
                        end
                        acked = 1'b1;
                    end else begin
                        #1;
                        check("wait_cache_wen", DW'(cache_wen), 0);
                    end
                end else if (acked && !do_wr) begin
                    check("refill_cache_wen", DW'(cache_wen), 1);
                    check("refill_cache_addr", cache_addr, addr);
                    check("refill_cache_din", cache_din, rd_val);
                end
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                if (acked) begin
                    cpu_addr  = addr;
                    cpu_wdata = wdata;
                    if (do_wr) begin
                        cpu_wen = 1'b0;
                        cpu_ren = 1'b0;
                    end
                end else if (scramble) begin
                    cpu_addr  = alt_addr;
                    cpu_wdata = $urandom;
                end
            end
        end

        check("txn_completed", DW'(done), 1);
        check("stall_cycles", DW'(stalls), DW'(exp_stall));
        if (do_rd && !do_wr) check("cpu_rdata", cpu_rdata, exp_rdata);
        if (idle_op) check("stray_ack_cache_wen", DW'(cache_wen), 0);

        @(posedge clk);
        #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        mem_ack = 1'b0;

        if (do_wr) begin
            ref_mem[addr]  = wdata;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_data[idx]  = wdata;
        end else if (do_rd) begin
            if (!exp_hit) begin
                if (exp_misses < CNT_MAX) exp_misses++;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tag;
                ref_data[idx]  = rd_val;
            end
            if (exp_hits < CNT_MAX) exp_hits++;
        end
        check("hit_count", DW'(hit_count), DW'(exp_hits));
        check("miss_count", DW'(miss_count), DW'(exp_misses));
        check("idle_mem_req", DW'(mem_req), 0);

        $display("txn %0d: wr=%0b rd=%0b addr=%h k=%0d stall_cycles=%0d hits=%0d misses=%0d",
                 n_txn, do_wr, do_rd, addr, k, stalls, hit_count, miss_count);
        n_txn++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] addr;
        int            op;

        #1;
        do_reset();

        // Reset in the middle of a read miss, before memory answers.
        cpu_addr = 32'h0000_03F0;
        cpu_ren  = 1'b1;
        @(negedge clk);
        check("t4_first_stall", DW'(stall), 1);
        @(posedge clk);
        #1;
        check("t4_miss_count", DW'(miss_count), 1);
        check("t4_mem_req", DW'(mem_req), 1);
        cpu_addr = 32'h0000_0500;
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_mem_req", DW'(mem_req), 0);
        check("t4_rst_idle_addr", cache_addr, 32'h0000_0500);
        check("t4_rst_hit_count", DW'(hit_count), 0);
        check("t4_rst_miss_count", DW'(miss_count), 0);
        cpu_ren = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t4_ack_mem_req", DW'(mem_req), 0);
        check("t4_ack_cache_wen", DW'(cache_wen), 0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("t4_after_ack_cache_wen", DW'(cache_wen), 0);
        check("t4_after_ack_stall", DW'(stall), 0);
        @(posedge clk);
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        $display("txn %0d: reset during read miss, stray ack afterwards", n_txn);
        n_txn++;

        // Store with ack latency 2, then a hitting load of the same word.
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 2, 1'b0, '0);
        run_txn(1'b0, 1'b1, 32'h0000_0040, '0, 1, 1'b0, '0);
        check("t1_hit_count", DW'(hit_count), 1);

        // Conflict miss in warm set 16, memory answers on the third cycle.
        do_reset();
        ref_mem[32'h0000_1040] = 32'h1234_5678;
        run_txn(1'b0, 1'b1, 32'h0000_1040, '0, 3, 1'b0, '0);
        check("t2_miss_count", DW'(miss_count), 1);
        check("t2_hit_count", DW'(hit_count), 1);

        // Store wins over a simultaneous load and counts nothing.
        run_txn(1'b1, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 1, 1'b0, '0);

        // CPU address wanders during the miss stall.
        run_txn(1'b0, 1'b1, 32'h0000_2100, '0, 4, 1'b1, 32'h0000_0200);

        // Hit counter saturation.
        for (int i = 0; i < 20; i++) begin
            run_txn(1'b0, 1'b1, 32'h0000_1040, '0, 1, 1'b0, '0);
        end
        check("t5_hit_saturated", DW'(hit_count), 15);

        // Randomized mix over a few sets and tags to get both hits and conflicts.
        for (int t = 0; t < 120; t++) begin
            if ((t % 40) == 39) do_reset();
            addr = {22'h0, 2'(($urandom_range(0, 2))), 8'h0};
            case ($urandom_range(0, 3))
                0:       addr[7:2] = 6'd1;
                1:       addr[7:2] = 6'd2;
                2:       addr[7:2] = 6'd3;
                default: addr[7:2] = 6'd16;
            endcase
            op = $urandom_range(0, 9);
            run_txn(op >= 5 && op <= 8, op <= 4 || op == 8, addr, $urandom,
                    $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
